// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC serial output path: state encoding and
// the frame length / conversion shift derivations.
package dac_spi_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   function automatic int frame_bits_f(input int pad_bits, input int dac_bits);
      return pad_bits + dac_bits;
   endfunction

   // Right shift that maps the [-1.0, 1.0) input range onto the DAC code range.
   function automatic int conv_shift_f(input int fraccion, input int dac_bits);
      return fraccion + 1 - dac_bits;
   endfunction

endpackage

// File: rtl/dac_spi_tx_sat_offset_bin.sv
// Combinational clip / optional round / shift / offset-binary stage.
// Build option: DAC_TX_ROUND_EN selects round-to-nearest instead of floor.
module sat_offset_bin
   import dac_spi_tx_pkg::*;
#(
   parameter int ancho_p  = 20,
   parameter int fraccion = 14,
   parameter int dac_bits = 12
) (
   input  logic signed [ancho_p-1:0]  func_sal,
   output logic        [dac_bits-1:0] code
);

   localparam int W1 = ancho_p + 1;
   localparam int SH = conv_shift_f(fraccion, dac_bits);

   localparam logic signed [ancho_p:0] MAX_V    = W1'((1 <<< fraccion) - 1);
   localparam logic signed [ancho_p:0] MIN_V    = ~MAX_V;
   localparam logic signed [ancho_p:0] CODE_MAX = W1'((1 <<< (dac_bits - 1)) - 1);
`ifdef DAC_TX_ROUND_EN
   localparam logic signed [ancho_p:0] HALF_LSB = W1'(1 <<< (SH - 1));
`endif

   // One guard bit keeps the rounding add from wrapping at the top of range.
   logic signed [ancho_p:0] sample_ext;
   logic signed [ancho_p:0] clipped;
   logic signed [ancho_p:0] biased;
   logic signed [ancho_p:0] shifted;
   logic signed [ancho_p:0] limited;
   logic                    unused_hi;

   assign sample_ext = {func_sal[ancho_p-1], func_sal};

   always_comb begin
      clipped = sample_ext;
      if (sample_ext > MAX_V) begin
         clipped = MAX_V;
      end else if (sample_ext < MIN_V) begin
         clipped = MIN_V;
      end
`ifdef DAC_TX_ROUND_EN
      biased = clipped + HALF_LSB;
`else
      biased = clipped;
`endif
      shifted = biased >>> SH;
      limited = (shifted > CODE_MAX) ? CODE_MAX : shifted;
      // Offset binary is two's complement with the sign bit inverted.
      code    = {~limited[dac_bits-1], limited[dac_bits-2:0]};
   end

   assign unused_hi = ^limited[ancho_p:dac_bits];

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: latches a converted sample on en and shifts a
// pad+data frame MSB first on sync_n/sclk/sdata, followed by a short gap.
// Build option: DAC_TX_ROUND_EN (rounding inside sat_offset_bin).
module dac_spi_tx
   import dac_spi_tx_pkg::*;
#(
   parameter int ancho_p  = 20,
   parameter int fraccion = 14,
   parameter int dac_bits = 12,
   parameter int pad_bits = 4,
   parameter int div      = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [ancho_p-1:0] func_sal,
   output logic               sclk,
   output logic               sync_n,
   output logic               sdata,
   output logic               busy,
   output logic               overrun
);

   localparam int FRAME_BITS = frame_bits_f(pad_bits, dac_bits);
   localparam int CNT_W      = $clog2(2 * div + 1);
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(div - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * div - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   logic [dac_bits-1:0]   code;
   logic [FRAME_BITS-1:0] frame_w;

   state_t                state;
   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      cnt;
   logic [BIT_W-1:0]      bit_cnt;

   sat_offset_bin #(
      .ancho_p  (ancho_p),
      .fraccion (fraccion),
      .dac_bits (dac_bits)
   ) u_conv (
      .func_sal (func_sal),
      .code     (code)
   );

   assign frame_w = {{pad_bits{1'b0}}, code};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         cnt     <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b1;
         sync_n  <= 1'b1;
         sdata   <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state   <= ST_SHIFT;
                  shreg   <= frame_w;
                  sdata   <= frame_w[FRAME_BITS-1];
                  sync_n  <= 1'b0;
                  sclk    <= 1'b1;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end

            ST_SHIFT: begin
               if (en) begin
                  overrun <= 1'b1;
               end
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (sclk) begin
                     sclk <= 1'b0;
                  end else begin
                     // Rising sclk: the DAC already took the bit on the falling edge.
                     sclk <= 1'b1;
                     if (bit_cnt == BIT_LAST) begin
                        state   <= ST_GAP;
                        sync_n  <= 1'b1;
                        sdata   <= 1'b0;
                        shreg   <= '0;
                        bit_cnt <= '0;
                     end else begin
                        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        sdata   <= shreg[FRAME_BITS-2];
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (en) begin
                  overrun <= 1'b1;
               end
               if (cnt == GAP_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state  <= ST_IDLE;
               sclk   <= 1'b1;
               sync_n <= 1'b1;
               sdata  <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: stimulus queues expected frames, a
// monitor decodes the serial line and checks frames, timing and overrun.
module tb_dac_spi_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [19:0] func_sal = 20'h0;
   logic        sclk, sync_n, sdata, busy, overrun;

   int checks = 0;
   int errors = 0;
   int exp_ovr = 0;
   int ovr_seen = 0;
   logic [15:0] exp_q[$];

   dac_spi_tx dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .func_sal (func_sal),
      .sclk     (sclk),
      .sync_n   (sync_n),
      .sdata    (sdata),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling clk edge, away from the active edge.
   logic prev_sclk = 1'b1, prev_sync = 1'b1, prev_busy = 1'b0, prev_ovr = 1'b0;
   logic [15:0] shv = '0;
   int nbits = 0, lo_cnt = 0, bz_cnt = 0, ov_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         nbits = 0; shv = '0; lo_cnt = 0; bz_cnt = 0; ov_cnt = 0;
      end else begin
         if (prev_sclk && !sclk && !sync_n) begin
            shv = {shv[14:0], sdata};
            nbits++;
         end
         if (!sync_n) lo_cnt++;
         if (!prev_sync && sync_n) begin
            logic [15:0] exp_f;
            chk("frame_bits", nbits, 16);
            chk("sync_low_clks", lo_cnt, 64);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", shv, 16'hxxxx);
            end else begin
               exp_f = exp_q.pop_front();
               $display("frame got=%04h exp=%04h", shv, exp_f);
               chk("frame_data", shv, exp_f);
            end
            nbits = 0; lo_cnt = 0;
         end
         if (busy) bz_cnt++;
         if (prev_busy && !busy) begin
            chk("busy_clks", bz_cnt, 68);
            bz_cnt = 0;
         end
         if (overrun) begin ov_cnt++; ovr_seen++; end
         if (prev_ovr && !overrun) begin
            chk("overrun_width", ov_cnt, 1);
            ov_cnt = 0;
         end
      end
      prev_sclk = sclk; prev_sync = sync_n; prev_busy = busy; prev_ovr = overrun;
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic send(input logic [19:0] v, input logic [11:0] c, input bit push);
      wait_idle();
      func_sal = v;
      en = 1'b1;
      if (push) exp_q.push_back({4'h0, c});
      @(negedge clk);
      en = 1'b0;
      func_sal = 20'h55555;
   endtask

   initial begin
      int rises;
      logic ps;

      repeat (3) @(negedge clk);
      chk("rst_sclk", sclk, 1);
      chk("rst_sync_n", sync_n, 1);
      chk("rst_sdata", sdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_outputs", {sclk, sync_n, sdata, busy, overrun}, 5'b11000);
      end

      send(20'h00000, 12'h800, 1);
      send(20'h04000, 12'hFFF, 1);
      send(20'h7FFFF, 12'hFFF, 1);
      send(20'hFC000, 12'h000, 1);
      send(20'h80000, 12'h000, 1);

      // Overrun mid-frame, then en on the gap-to-idle edge, then immediate accept.
      send(20'h01000, 12'hA00, 1);
      repeat (9) @(negedge clk);
      func_sal = 20'h7FFFF; en = 1'b1; exp_ovr++;
      @(negedge clk);
      en = 1'b0;
      repeat (57) @(negedge clk);
      func_sal = 20'h7FFFF; en = 1'b1; exp_ovr++;
      @(negedge clk);
      en = 1'b0;
      chk("accept_after_busy", busy, 0);
      send(20'hFFFFB, 12'h7FF, 1);

      // Abort a frame with reset after the 7th rising sclk.
      send(20'h7FFFF, 12'hFFF, 0);
      rises = 0;
      ps = sclk;
      for (int i = 0; i < 300 && rises < 7; i++) begin
         @(negedge clk);
         if (!ps && sclk) rises++;
         ps = sclk;
      end
      chk("abort_rises", rises, 7);
      #2 reset = 1'b0;
      #1;
      chk("abort_sync_n", sync_n, 1);
      chk("abort_sclk", sclk, 1);
      chk("abort_busy", busy, 0);
      chk("abort_sdata", sdata, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      send(20'h02000, 12'hC00, 1);

`ifdef DAC_TX_ROUND_EN
      send(20'h00004, 12'h801, 1);
`else
      send(20'h00004, 12'h800, 1);
`endif
      send(20'h03FFF, 12'hFFF, 1);

      wait_idle();
      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("overrun_count", ovr_seen, exp_ovr);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Output end of the equalizer sample path. On each sample strobe it takes the signed fixed-point sum of the filter bank outputs. It saturates the sample to the DAC full scale, converts it to offset-binary, and shifts it MSB-first as a 16-bit frame to a serial DAC (sync_n/sclk/sdata, 12-bit data). It runs from the same clk and en strobe as the filter registers.

Parameters:
ancho_p, 20, width of the incoming signed sample (Q signo.magnitud.fraccion)
fraccion, 14, fractional bits of the incoming sample
dac_bits, 12, DAC data width
pad_bits, 4, leading zero/control bits per frame; frame length = pad_bits + dac_bits = 16
div, 2, clk cycles per sclk half-period; minimum 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (reset=0 resets)
en  input  1  sample strobe, one clk wide, shared with the filter registers
func_sal  input  ancho_p  signed sample to output
sclk  output  1  serial clock to DAC; idles high
sync_n  output  1  frame select, active low
sdata  output  1  serial data, MSB first
busy  output  1  high while a frame is in flight, including the gap
overrun  output  1  one-cycle pulse when en arrives while busy

Behaviour:
- Reset (reset=0, async): state IDLE, sclk=1, sync_n=1, sdata=0, busy=0, overrun=0, and all counters cleared. Reset mid-frame aborts the frame immediately. There is no partial completion.
- Conversion (combinational on func_sal):
  - Clip to [-2^fraccion, 2^fraccion-1], i.e. the [-1.0, 1.0) range.
  - Arithmetic right shift by sh = fraccion+1-dac_bits (3 with defaults).
  - Add 2^(dac_bits-1).
  - Result is 0..2^dac_bits-1; 0 maps to 0x800.
- States:
  - IDLE: busy=0. If en=1, latch {pad zeros, code} into a 16-bit shift register, go to SHIFT, and set busy=1 on the next edge.
  - SHIFT:
    - sync_n=0 and sdata=shreg MSB. sclk starts high, falls after div clks (the DAC samples on the falling edge), then rises after another div clks.
    - On each rising edge of sclk the register shifts left and the bit counter increments.
    - After the 16th rising edge, go to GAP.
    - Frame length is 32*div clks.
  - GAP: sync_n=1, sclk=1, sdata=0 for 2*div clks, then IDLE.
  - Total busy time = 34*div clks (68 with defaults).
- en while busy (SHIFT or GAP): the sample is dropped, overrun pulses for exactly 1 clk, and the frame in flight is unaffected. en in the same cycle as the GAP→IDLE transition is also dropped.
- en on the first IDLE cycle is accepted.
- The sample is latched at acceptance. Later changes on func_sal do not affect the frame.
- No combinational path from en/func_sal to any output. All outputs are registered.

Optional Feature:
- Macro: DAC_TX_ROUND_EN.
- Defined: round to nearest by adding 2^(sh-1) to the clipped value before the shift, then re-saturate the result to 2^(dac_bits-1)-1.
- Undefined: truncate (floor via arithmetic shift).
- Frame timing is identical in both builds.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE, ST_SHIFT, ST_GAP
  - the FRAME_BITS derivation
  - the conversion shift derivation sh
- One natural sub-module: sat_offset_bin, a purely combinational clip/round/shift/offset stage parameterized by ancho_p, fraccion, dac_bits. It is reused by any future DAC channel.

Test Plan:
- Reset held low → sclk=1, sync_n=1, sdata=0, busy=0, overrun=0. Release, hold en=0 for 100 clks → outputs unchanged.
- func_sal=0, en pulse → bits captured on 16 sclk falling edges = 0000_1000_0000_0000. busy high for 68 clks. sync_n low for 64 clks, then high for 4.
- Saturation checks:
  - func_sal=20'h04000 (+1.0) → code 0xFFF
  - func_sal=20'h7FFFF → 0xFFF
  - func_sal=20'hFC000 (-1.0) → 0x000
  - func_sal=20'h80000 → 0x000
- en pulse at clk 10 of a frame in flight → overrun high exactly 1 clk. Captured frame equals the first sample. The next en after busy falls is accepted normally.
- reset driven low after the 7th sclk rising edge → sync_n=1 and sclk=1 asynchronously. After release, en with func_sal=20'h02000 → full fresh frame with code 0xC00.
- func_sal=20'sd4:
  - without DAC_TX_ROUND_EN → 0x800
  - with it → 0x801
- func_sal=20'sd16383 with DAC_TX_ROUND_EN → 0xFFF (re-saturated).
